// File: rtl/gray_chk_pkg.sv
// Shared state encodings, default width and a saturating increment helper for the Gray stream checker.
package gray_chk_pkg;

    localparam int unsigned GRAY_W_DEFAULT = 3;

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] LOCKED   = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gray_stream_checker_if.sv
// Sample/status bundle between the Gray counter side (master) and the stream checker (slave).
interface gray_stream_checker_if
    import gray_chk_pkg::*;
#(
    parameter int unsigned W      = GRAY_W_DEFAULT,
    parameter int unsigned ECNT_W = 8,
    parameter int unsigned WCNT_W = 8
);

    logic              Clear;
    logic              Valid;
    logic [W-1:0]      Gray;
    logic              Ovf_in;
    logic [W-1:0]      Bin_out;
    logic              Bin_valid;
    logic              Locked;
    logic              Step_err;
    logic              Ovf_err;
    logic [ECNT_W-1:0] Err_count;
    logic [WCNT_W-1:0] Wrap_count;

    modport master (
        output Clear, Valid, Gray, Ovf_in,
        input  Bin_out, Bin_valid, Locked, Step_err, Ovf_err, Err_count, Wrap_count
    );

    modport slave (
        input  Clear, Valid, Gray, Ovf_in,
        output Bin_out, Bin_valid, Locked, Step_err, Ovf_err, Err_count, Wrap_count
    );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion.
module gray2bin #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    // Prefix XOR from the MSB down.
    always_comb begin
        logic [W-1:0] b;
        b        = '0;
        b[W-1]   = gray[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray[i];
        end
        bin_c = b;
    end

endmodule

// File: rtl/gray_stream_checker.sv
// Checks that a sampled Gray stream advances by exactly +1 per sample; tracks lock, errors, wraps, overflow.
module gray_stream_checker
    import gray_chk_pkg::*;
#(
    parameter int unsigned W      = GRAY_W_DEFAULT,
    parameter int unsigned ECNT_W = 8,
    parameter int unsigned WCNT_W = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    gray_stream_checker_if.slave  bus
);

    localparam logic [W-1:0] BIN_MAX = '1;

    logic [1:0]        state_q,    state_d;
    logic [W-1:0]      prev_q,     prev_d;
    logic [W-1:0]      bin_out_q,  bin_out_d;
    logic              bin_vld_q,  bin_vld_d;
    logic              locked_q,   locked_d;
    logic              step_err_q, step_err_d;
    logic              ovf_err_q,  ovf_err_d;
    logic [ECNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [WCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [W-1:0]      bin_c;
    logic [W-1:0]      exp_bin_c;
    logic              is_step_c;
    logic              is_wrap_c;

    gray2bin #(.W(W)) u_gray2bin (
        .gray  (bus.Gray),
        .bin_c (bin_c)
    );

    assign exp_bin_c = prev_q + W'(1);
    assign is_step_c = (bin_c == exp_bin_c);
    assign is_wrap_c = is_step_c && (prev_q == BIN_MAX);

    // State register and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= UNLOCKED;
            prev_q     <= '0;
            bin_out_q  <= '0;
            bin_vld_q  <= 1'b0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            bin_out_q  <= bin_out_d;
            bin_vld_q  <= bin_vld_d;
            locked_q   <= locked_d;
            step_err_q <= step_err_d;
            ovf_err_q  <= ovf_err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    // Next-state, step/overflow checks and counter updates; Clear discards a coincident sample.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        bin_out_d  = bin_out_q;
        bin_vld_d  = 1'b0;
        step_err_d = step_err_q;
        ovf_err_d  = ovf_err_q;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;

        if (bus.Clear) begin
            state_d    = UNLOCKED;
            prev_d     = '0;
            bin_out_d  = '0;
            step_err_d = 1'b0;
            ovf_err_d  = 1'b0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else if (bus.Valid) begin
            bin_out_d = bin_c;
            bin_vld_d = 1'b1;
            prev_d    = bin_c;
            case (state_q)
                LOCKED: begin
                    if (is_step_c) begin
                        if (is_wrap_c) begin
                            wrap_cnt_d = WCNT_W'(sat_inc(32'(wrap_cnt_q), WCNT_W));
                        end
                    end else begin
                        step_err_d = 1'b1;
                        err_cnt_d  = ECNT_W'(sat_inc(32'(err_cnt_q), ECNT_W));
                        state_d    = FAULT;
                    end
                    // Overflow must appear with the first wrap and stay set afterwards.
                    if (bus.Ovf_in && (wrap_cnt_q == '0) && !is_wrap_c) begin
                        ovf_err_d = 1'b1;
                    end
                    if (!bus.Ovf_in && (wrap_cnt_q != '0)) begin
                        ovf_err_d = 1'b1;
                    end
                end
                default: begin
                    // UNLOCKED, FAULT and any illegal code resync on this sample without checking.
                    state_d = LOCKED;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    assign bus.Bin_out    = bin_out_q;
    assign bus.Bin_valid  = bin_vld_q;
    assign bus.Locked     = locked_q;
    assign bus.Step_err   = step_err_q;
    assign bus.Ovf_err    = ovf_err_q;
    assign bus.Err_count  = err_cnt_q;
    assign bus.Wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Scoreboard bench for gray_stream_checker: directed samples push expected results, a monitor compares on Bin_valid.
module tb_gray_stream_checker;

    typedef struct packed {
        logic [2:0] bin;
        logic       locked;
        logic       step;
        logic       ovf;
        logic [7:0] err;
        logic [7:0] wrap;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    gray_stream_checker_if #(.W(3), .ECNT_W(8), .WCNT_W(8)) bus ();

    gray_stream_checker #(.W(3), .ECNT_W(8), .WCNT_W(8)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] b, input logic l, input logic s, input logic o,
                                input int e, input int w);
        exp_t x;
        x.bin = b; x.locked = l; x.step = s; x.ovf = o; x.err = 8'(e); x.wrap = 8'(w);
        return x;
    endfunction

    function automatic exp_t cur();
        return mk(bus.Bin_out, bus.Locked, bus.Step_err, bus.Ovf_err,
                  int'(bus.Err_count), int'(bus.Wrap_count));
    endfunction

    task automatic check_all(input string tag, input exp_t a, input exp_t e);
        check({tag, ".bin"},    32'(a.bin),    32'(e.bin));
        check({tag, ".locked"}, 32'(a.locked), 32'(e.locked));
        check({tag, ".step"},   32'(a.step),   32'(e.step));
        check({tag, ".ovf"},    32'(a.ovf),    32'(e.ovf));
        check({tag, ".err"},    32'(a.err),    32'(e.err));
        check({tag, ".wrap"},   32'(a.wrap),   32'(e.wrap));
    endtask

    // Monitor: every Bin_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.Bin_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_bin_valid: got pulse, want none at %0t", $time);
            end else begin
                check_all("sample", cur(), exp_q.pop_front());
            end
        end
    end

    // One accepted sample; leaves Valid low unless the next call raises it again.
    task automatic send(input logic [2:0] g, input logic ovf, input exp_t e);
        bus.Valid  = 1'b1;
        bus.Gray   = g;
        bus.Ovf_in = ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_bin_valid", 32'(bus.Bin_valid), 32'd0);
        end
    endtask

    task automatic do_clear(input logic with_valid, input string tag);
        bus.Clear = 1'b1;
        bus.Valid = with_valid;
        bus.Gray  = 3'b010;
        @(posedge clk);
        #1;
        bus.Clear = 1'b0;
        bus.Valid = 1'b0;
        check_all(tag, cur(), mk(3'd0, 1'b0, 1'b0, 1'b0, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus.Clear  = 1'b0;
        bus.Valid  = 1'b0;
        bus.Gray   = 3'd0;
        bus.Ovf_in = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset", cur(), mk(3'd0, 1'b0, 1'b0, 1'b0, 0, 0));
        check("reset_bin_valid", 32'(bus.Bin_valid), 32'd0);

        // Clean full cycle with Overflow on the wrap sample.
        send(3'b000, 1'b0, mk(3'd0, 1, 0, 0, 0, 0));
        send(3'b001, 1'b0, mk(3'd1, 1, 0, 0, 0, 0));
        send(3'b011, 1'b0, mk(3'd2, 1, 0, 0, 0, 0));
        send(3'b010, 1'b0, mk(3'd3, 1, 0, 0, 0, 0));
        send(3'b110, 1'b0, mk(3'd4, 1, 0, 0, 0, 0));
        send(3'b111, 1'b0, mk(3'd5, 1, 0, 0, 0, 0));
        send(3'b101, 1'b0, mk(3'd6, 1, 0, 0, 0, 0));
        send(3'b100, 1'b0, mk(3'd7, 1, 0, 0, 0, 0));
        send(3'b000, 1'b1, mk(3'd0, 1, 0, 0, 0, 1));

        // Skip 2 -> 5, then resync on 6 and continue to 7.
        send(3'b001, 1'b1, mk(3'd1, 1, 0, 0, 0, 1));
        send(3'b011, 1'b1, mk(3'd2, 1, 0, 0, 0, 1));
        send(3'b111, 1'b1, mk(3'd5, 0, 1, 0, 1, 1));
        send(3'b101, 1'b1, mk(3'd6, 1, 1, 0, 1, 1));
        send(3'b100, 1'b1, mk(3'd7, 1, 1, 0, 1, 1));
        idle(1);

        // Gaps between samples.
        do_clear(1'b0, "clear1");
        send(3'b000, 1'b0, mk(3'd0, 1, 0, 0, 0, 0));
        idle(10);
        send(3'b001, 1'b0, mk(3'd1, 1, 0, 0, 0, 0));
        idle(10);
        send(3'b011, 1'b0, mk(3'd2, 1, 0, 0, 0, 0));

        // Repeated code alternates error / resync; counter saturates at 255.
        for (int k = 1; k <= 300; k++) begin
            send(3'b011, 1'b0, mk(3'd2, 0, 1, 0, (k > 255) ? 255 : k, 0));
            send(3'b011, 1'b0, mk(3'd2, 1, 1, 0, (k > 255) ? 255 : k, 0));
        end
        idle(1);
        check("err_saturated", 32'(bus.Err_count), 32'd255);

        // Overflow without a wrap.
        do_clear(1'b0, "clear2");
        send(3'b000, 1'b0, mk(3'd0, 1, 0, 0, 0, 0));
        send(3'b001, 1'b1, mk(3'd1, 1, 0, 1, 0, 0));
        send(3'b011, 1'b0, mk(3'd2, 1, 0, 1, 0, 0));
        idle(1);

        // Asynchronous reset between edges, then relock.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", cur(), mk(3'd0, 1'b0, 1'b0, 1'b0, 0, 0));
        check("async_reset_bin_valid", 32'(bus.Bin_valid), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(3'b110, 1'b0, mk(3'd4, 1, 0, 0, 0, 0));
        send(3'b111, 1'b0, mk(3'd5, 1, 0, 0, 0, 0));
        idle(1);

        // Clear wins over a coincident sample; next sample is a fresh lock.
        do_clear(1'b1, "clear_valid");
        check("clear_valid_bin_valid", 32'(bus.Bin_valid), 32'd0);
        send(3'b000, 1'b0, mk(3'd0, 1, 0, 0, 0, 0));
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
